// File: rtl/sync_filter.sv
// Multi-channel input synchronizer with per-channel stable-count glitch filter
// and registered rise/fall pulses on the filtered level.

module sync_filter_lane #(
  parameter int   NSTAGES = 2,
  parameter int   FILTCNT = 4,
  parameter logic RST     = 1'b0
) (
  input  logic clk,
  input  logic reset_l,
  input  logic en,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall
);

  logic [NSTAGES-1:0] sync_q, sync_d;
  logic               s;
  logic               o_q, o_d;
  logic               rise_q, fall_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = i;
    for (int k = 1; k < NSTAGES; k++) sync_d[k] = sync_q[k-1];
  end

  // Sync chain shifts every clock regardless of en.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) sync_q <= {NSTAGES{RST}};
    else          sync_q <= sync_d;
  end

  assign s = sync_q[NSTAGES-1];

  if (FILTCNT == 0) begin : g_bypass
    logic unused_en;
    assign unused_en = en;
    assign o_d       = s;
  end else begin : g_filt
    localparam int            CW   = $clog2(FILTCNT + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTCNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A mismatch must survive FILTCNT qualified samples; any agreement restarts it.
    always_comb begin
      cnt_d = cnt_q;
      o_d   = o_q;
      if (en) begin
        if (s == o_q) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          o_d   = s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      o_q    <= RST;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      rise_q <= o_d & ~o_q;
      fall_q <= ~o_d & o_q;
    end
  end

  assign o    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

module sync_filter #(
  parameter int               NCHAN     = 1,
  parameter int               NSTAGES   = 2,
  parameter int               FILTCNT   = 4,
  parameter logic [NCHAN-1:0] RESET_VAL = '0
) (
  input  logic             reset_l,
  input  logic             clk,
  input  logic             en,
  input  logic [NCHAN-1:0] i,
  output logic [NCHAN-1:0] o,
  output logic [NCHAN-1:0] rise,
  output logic [NCHAN-1:0] fall
);

  if (NSTAGES < 1) begin : g_bad_nstages
    $error("sync_filter: NSTAGES must be >= 1");
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_lane
    sync_filter_lane #(
      .NSTAGES (NSTAGES),
      .FILTCNT (FILTCNT),
      .RST     (RESET_VAL[g])
    ) u_lane (
      .clk     (clk),
      .reset_l (reset_l),
      .en      (en),
      .i       (i[g]),
      .o       (o[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: three configurations share clock and reset,
// each phase drives one instance and checks against hand-derived cycle counts.

module tb_sync_filter;

  logic clk = 1'b0;
  logic reset_l;

  // u0: defaults (1 chan, NSTAGES=2, FILTCNT=4, RESET_VAL=0)
  logic en0, i0, o0, rise0, fall0;
  // u1: 4 chans, RESET_VAL=1010
  logic       en1;
  logic [3:0] i1, o1, rise1, fall1;
  // u2: bypass, NSTAGES=3
  logic en2, i2, o2, rise2, fall2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_filter u0 (
    .reset_l (reset_l), .clk (clk), .en (en0), .i (i0),
    .o (o0), .rise (rise0), .fall (fall0)
  );

  sync_filter #(.NCHAN(4), .RESET_VAL(4'b1010)) u1 (
    .reset_l (reset_l), .clk (clk), .en (en1), .i (i1),
    .o (o1), .rise (rise1), .fall (fall1)
  );

  sync_filter #(.NSTAGES(3), .FILTCNT(0)) u2 (
    .reset_l (reset_l), .clk (clk), .en (en2), .i (i2),
    .o (o2), .rise (rise2), .fall (fall2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic exp2(int k);
    if (k < 4) return 1'b0;
    return (((k - 4) / 5) % 2) == 1;
  endfunction

  initial begin
    reset_l = 1'b0;
    en0 = 1'b1; i0 = 1'b0;
    en1 = 1'b1; i1 = 4'b1010;
    en2 = 1'b0; i2 = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_o0",    4'(o0),    4'b0);
    chk("rst_rise0", 4'(rise0), 4'b0);
    chk("rst_fall0", 4'(fall0), 4'b0);
    chk("rst_o1",    o1,        4'b1010);
    chk("rst_o2",    4'(o2),    4'b0);
    reset_l = 1'b1;

    // no pulses on reset exit
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("exit_o0",    4'(o0),    4'b0);
      chk("exit_pulse0", {rise0, fall0, 2'b00}, 4'b0);
      chk("exit_o1",    o1,        4'b1010);
      chk("exit_rise1", rise1,     4'b0);
      chk("exit_fall1", fall1,     4'b0);
    end

    // basic rise: o after NSTAGES+FILTCNT = 6 clocks
    i0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("lat_o",    4'(o0),    4'(k >= 6));
      chk("lat_rise", 4'(rise0), 4'(k == 6));
      chk("lat_fall", 4'(fall0), 4'b0);
    end

    // fall back to 0
    i0 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("fall_o",    4'(o0),    4'(k < 6));
      chk("fall_fall", 4'(fall0), 4'(k == 6));
      chk("fall_rise", 4'(rise0), 4'b0);
    end

    // glitch of 3 cycles is rejected
    i0 = 1'b1;
    tick(); tick(); tick();
    i0 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("glitch_o",    4'(o0),    4'b0);
      chk("glitch_rise", 4'(rise0), 4'b0);
    end

    // 4-cycle pulse passes, then falls
    i0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) i0 = 1'b0;
      chk("pass_o",    4'(o0),    4'(k >= 6 && k < 10));
      chk("pass_rise", 4'(rise0), 4'(k == 6));
      chk("pass_fall", 4'(fall0), 4'(k == 10));
    end

    // en every 4th clock: o follows on the 4th strobe after s changes
    i0  = 1'b1;
    en0 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("en_o",    4'(o0),    4'(k >= 16));
      chk("en_rise", 4'(rise0), 4'(k == 16));
      en0 = ((k + 1) % 4) == 0;
    end

    // s reverts between strobes, strobe 12 sees agreement and clears the count
    i0  = 1'b0;
    en0 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 8)  i0 = 1'b1;
      if (k == 10) i0 = 1'b0;
      chk("enclr_o",    4'(o0),    4'(k < 28));
      chk("enclr_fall", 4'(fall0), 4'(k == 28));
      en0 = ((k + 1) % 4) == 0;
    end
    en0 = 1'b1;

    // 4 channels switch together
    i1 = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("mc_o",    o1,    (k >= 6) ? 4'b0101 : 4'b1010);
      chk("mc_rise", rise1, (k == 6) ? 4'b0101 : 4'b0000);
      chk("mc_fall", fall1, (k == 6) ? 4'b1010 : 4'b0000);
    end

    // bypass: o follows i with 4 clocks of latency, en ignored
    for (int k = 1; k <= 30; k++) begin
      i2  = 1'(((k - 1) / 5) % 2);
      en2 = 1'(k % 2);
      tick();
      chk("byp_o",    4'(o2),    4'(exp2(k)));
      chk("byp_rise", 4'(rise2), 4'(exp2(k) & ~exp2(k - 1)));
      chk("byp_fall", 4'(fall2), 4'(~exp2(k) & exp2(k - 1)));
    end

    // reset mid-count: counter at 3, then reset with i held high
    i0 = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    chk("pre_rst_o0", 4'(o0), 4'b0);
    reset_l = 1'b0;
    #1;
    chk("midrst_o0",  4'(o0), 4'b0);
    chk("midrst_o1",  o1,     4'b1010);
    chk("midrst_r1",  rise1,  4'b0);
    tick(); tick();
    reset_l = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("rstx_o",    4'(o0),    4'(k >= 6));
      chk("rstx_rise", 4'(rise0), 4'(k == 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
Multi-channel synchronizer with per-channel glitch filter and edge-pulse outputs. Used on asynchronous inputs from pins, switches or slow status lines before they reach control logic in the clk domain. Each channel is resynchronized through NSTAGES flops. The output changes only after the synchronized value has held a new level for FILTCNT qualifying cycles.

Parameters:
NCHAN, 1, number of independent channels.
NSTAGES, 2, synchronizer flop depth; minimum 1; elaboration error if less than 1.
FILTCNT, 4, required stable-sample count before the output follows; 0 = filter bypass.
RESET_VAL, 0, NCHAN-bit reset value for synchronizer flops and o.

Ports:
reset_l  input  1  asynchronous active-low reset
clk  input  1  clock
en  input  1  sample-qualify strobe for filter counting; tie to 1 for per-clock filtering
i  input  NCHAN  asynchronous input levels
o  output  NCHAN  filtered synchronized levels
rise  output  NCHAN  one-cycle pulse when o goes 0->1
fall  output  NCHAN  one-cycle pulse when o goes 1->0

Behaviour:
- Reset (async assert, sync deassert by system):
  - all sync flops = RESET_VAL
  - o = RESET_VAL
  - filter counters = 0
  - rise = fall = 0
  - No edge pulse is generated on reset exit.
- Sync chain:
  - shifts every clk, independent of en.
  - s = last stage.
  - Latency from i to s is NSTAGES clocks.
- Filter, per channel, counter width clog2(FILTCNT+1), evaluated only on cycles with en=1:
  - s == o: counter cleared to 0.
  - s != o and counter == FILTCNT-1: o <= s; counter <= 0.
  - s != o otherwise: counter increments.
- en=0:
  - counter and o hold.
  - sync chain still shifts.
- Glitch rejection: a mismatch that reverts before the count completes clears the counter. The next mismatch restarts from 0.
- FILTCNT=1: o follows s on the first en cycle with a mismatch.
- FILTCNT=0 (bypass):
  - o <= s every clk; en ignored; no counter logic.
- Latency with en tied 1:
  - i level change to o change = NSTAGES+FILTCNT clocks for FILTCNT>=1.
  - NSTAGES+1 clocks in bypass.
- Edge pulses:
  - rise[n] = 1 exactly in the cycle o[n] first shows 1 after being 0 (registered alongside o).
  - fall[n] likewise for 1->0.
  - rise and fall are never both 1 on the same channel.
  - Back-to-back toggles of o produce separate pulses.
- Channels are fully independent: simultaneous changes on several channels produce simultaneous pulses.
- Reset mid-count: counter and o return to reset values immediately; any partial count is lost.
- Counter never exceeds FILTCNT-1, so there is no wrap-around.

Test Plan:
- Default params (NCHAN=1, en=1), reset released with i=0; i rises at cycle 10 and holds -> o=1 and rise=1 for one cycle at cycle 16 (2+4); fall stays 0; o=0 and no pulses during reset exit.
- Glitch: i=1 for 3 cycles then 0 (en=1, FILTCNT=4) -> o stays 0, no rise. Then i=1 for 4 cycles -> o=1 after 6 cycles, rise pulse once; i back to 0 later -> fall pulse once.
- en strobe every 4th clk, FILTCNT=4, i steps 0->1 -> o changes on the 4th en strobe after s changes; counter holds between strobes; a reversion of s to 0 between strobes, caught by an en strobe, clears the count.
- NCHAN=4, RESET_VAL=4'b1010: after reset o=1010. Apply i=0101 simultaneously -> all four channels switch in the same cycle, rise=0101, fall=1010 in one cycle.
- FILTCNT=0, NSTAGES=3: i toggles each 5 clocks -> o follows with 4-clock latency; one pulse per transition; en ignored.
- Assert reset_l low with the counter at 3 of 4 and i=1 -> o=RESET_VAL immediately. After release with i still 1, a full NSTAGES+FILTCNT delay elapses before o=1 with a rise pulse.
